// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle Moore control unit for the Phase-3 datapath.
// Sequences fetch (T0-T2) and opcode-dependent execute steps (T3-T7). It stalls
// memory steps on mem_ready, applies a bounded memory timeout, honours Stop only
// at instruction boundaries, and flags unknown opcodes.
//
// Ports:
//   clk              system clock, rising edge
//   Reset            asynchronous, active-high reset
//   ir               instruction register, opcode = ir[31:27]
//   mem_ready        memory completes the current ReadRAM/WriteRAM step
//   Stop             halt request, level-sampled on clk
//   run              1 while executing
//   MD_Read, ReadRAM, WriteRAM          memory controls
//   Gra, Grb, Grc, Rin, Rout, BAout     register-file select/control
//   enable           one-hot register load enables (EN_W bits)
//   busSelect        one-hot bus driver select (SEL_W bits)
//   Control_Signals  ALU op code (0 = idle, 14 = IncPC)
//   step             current step T0..T7
//   illegal          sticky: unknown opcode seen
//   mem_err          sticky: memory timeout
module ctrl_sequencer #(
    parameter int EN_W        = 32,
    parameter int SEL_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             Stop,
    output logic             run,
    output logic             MD_Read,
    output logic             ReadRAM,
    output logic             WriteRAM,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic [EN_W-1:0]  enable,
    output logic [SEL_W-1:0] busSelect,
    output logic [4:0]       Control_Signals,
    output logic [2:0]       step,
    output logic             illegal,
    output logic             mem_err
);

    // enable bit positions
    localparam int Z_IN = 18, Y_IN = 19, PC_IN = 20, MDR_IN = 21;
    localparam int HI_IN = 22, LO_IN = 23, IR_IN = 24, MAR_IN = 25;
    // busSelect bit positions (HIout=16 and LOout=17 are never driven by this sequence)
    localparam int ZHI_OUT = 18, ZLO_OUT = 19, PC_OUT = 20, MDR_OUT = 21, C_OUT = 22;

    localparam logic [4:0] CS_INC_PC = 5'd14;
    localparam logic [4:0] CS_ADD    = 5'd3;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    // T-states share their step number so step can be read straight off the code.
    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_RESET = 4'd8, S_HALT = 4'd9
    } state_e;

    // Halt never needs storing and an illegal opcode executes as a nop.
    typedef enum logic [2:0] { K_RTYPE, K_MULDIV, K_LD, K_ST, K_NOP } kind_e;

    typedef struct packed {
        logic             run;
        logic             md_read;
        logic             read_ram;
        logic             write_ram;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             rin;
        logic             rout;
        logic             baout;
        logic [EN_W-1:0]  en;
        logic [SEL_W-1:0] sel;
        logic [4:0]       cs;
        logic [2:0]       step;
    } ctrl_t;

    state_e     state_q, state_d;
    kind_e      kind_q, kind_d;
    logic [4:0] opc_q, opc_d;
    logic [7:0] wait_q, wait_d;
    logic       stop_q, stop_d;
    logic       illegal_q, illegal_d;
    logic       mem_err_q, mem_err_d;
    ctrl_t      ctrl_q;

    // The low instruction bits belong to the datapath, not the sequencer.
    logic unused_ir;
    assign unused_ir = ^ir[26:0];

    function automatic logic is_mem_step(state_e s, kind_e k);
        return (s == S_T1) || (s == S_T6 && k == K_LD) || (s == S_T7 && k == K_ST);
    endfunction

    function automatic logic is_last_step(state_e s, kind_e k);
        case (k)
            K_RTYPE:    return s == S_T5;
            K_MULDIV:   return s == S_T6;
            K_LD, K_ST: return s == S_T7;
            default:    return s == S_T3;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(state_e s, kind_e k, logic [4:0] opc);
        ctrl_t c;
        c = '0;
        if (s != S_RESET && s != S_HALT) begin
            c.run  = 1'b1;
            c.step = s[2:0];
            case (s)
                S_T0: begin c.sel[PC_OUT] = 1'b1; c.en[MAR_IN] = 1'b1; c.en[Z_IN] = 1'b1; c.cs = CS_INC_PC; end
                S_T1: begin
                    c.sel[ZLO_OUT] = 1'b1; c.en[PC_IN] = 1'b1; c.en[MDR_IN] = 1'b1;
                    c.md_read = 1'b1; c.read_ram = 1'b1;
                end
                S_T2: begin c.sel[MDR_OUT] = 1'b1; c.en[IR_IN] = 1'b1; end
                S_T3: case (k)
                    K_RTYPE:    begin c.grb = 1'b1; c.rout  = 1'b1; c.en[Y_IN] = 1'b1; end
                    K_MULDIV:   begin c.gra = 1'b1; c.rout  = 1'b1; c.en[Y_IN] = 1'b1; end
                    K_LD, K_ST: begin c.grb = 1'b1; c.baout = 1'b1; c.en[Y_IN] = 1'b1; end
                    default: ;
                endcase
                S_T4: case (k)
                    K_RTYPE:    begin c.grc = 1'b1; c.rout = 1'b1; c.en[Z_IN] = 1'b1; c.cs = opc; end
                    K_MULDIV:   begin c.grb = 1'b1; c.rout = 1'b1; c.en[Z_IN] = 1'b1; c.cs = opc; end
                    K_LD, K_ST: begin c.sel[C_OUT] = 1'b1; c.en[Z_IN] = 1'b1; c.cs = CS_ADD; end
                    default: ;
                endcase
                S_T5: case (k)
                    K_RTYPE:    begin c.sel[ZLO_OUT] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    K_MULDIV:   begin c.sel[ZLO_OUT] = 1'b1; c.en[LO_IN] = 1'b1; end
                    K_LD, K_ST: begin c.sel[ZLO_OUT] = 1'b1; c.en[MAR_IN] = 1'b1; end
                    default: ;
                endcase
                S_T6: case (k)
                    K_MULDIV: begin c.sel[ZHI_OUT] = 1'b1; c.en[HI_IN] = 1'b1; end
                    K_LD:     begin c.read_ram = 1'b1; c.md_read = 1'b1; c.en[MDR_IN] = 1'b1; end
                    K_ST:     begin c.gra = 1'b1; c.rout = 1'b1; c.en[MDR_IN] = 1'b1; end
                    default: ;
                endcase
                S_T7: case (k)
                    K_LD:    begin c.sel[MDR_OUT] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    K_ST:    c.write_ram = 1'b1;
                    default: ;
                endcase
                default: ;
            endcase
        end
        return c;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        kind_d    = kind_q;
        opc_d     = opc_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        // Stop sampled on this edge already counts toward the boundary decision.
        stop_d    = stop_q | (Stop & ctrl_q.run);

        case (state_q)
            S_RESET: state_d = S_T0;
            S_HALT:  ;
            default: begin
                if (is_mem_step(state_q, kind_q) && !mem_ready) begin
                    // Hold the step; wait_q counts stall cycles already spent in it.
                    if (wait_q == WAIT_LAST) begin
                        mem_err_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else if (state_q == S_T2) begin
                    opc_d   = ir[31:27];
                    state_d = S_T3;
                    if (ir[31:27] inside {[5'd3:5'd9]}) begin
                        kind_d = K_RTYPE;
                    end else begin
                        case (ir[31:27])
                            5'b00000:          kind_d = K_LD;
                            5'b00010:          kind_d = K_ST;
                            5'b01111, 5'b10000: kind_d = K_MULDIV;
                            5'b11010:          kind_d = K_NOP;
                            5'b11011: begin kind_d = K_NOP; state_d = S_HALT; end
                            default:  begin kind_d = K_NOP; illegal_d = 1'b1; end
                        endcase
                    end
                end else if (is_last_step(state_q, kind_q)) begin
                    state_d = stop_d ? S_HALT : S_T0;
                end else begin
                    state_d = state_e'(state_q + 4'd1);
                end
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // only on clk and never follow ir combinationally.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_RESET;
            kind_q    <= K_NOP;
            opc_q     <= '0;
            wait_q    <= '0;
            stop_q    <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            kind_q    <= kind_d;
            opc_q     <= opc_d;
            wait_q    <= wait_d;
            stop_q    <= stop_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            ctrl_q    <= decode_ctrl(state_d, kind_d, opc_d);
        end
    end

    assign run             = ctrl_q.run;
    assign MD_Read         = ctrl_q.md_read;
    assign ReadRAM         = ctrl_q.read_ram;
    assign WriteRAM        = ctrl_q.write_ram;
    assign Gra             = ctrl_q.gra;
    assign Grb             = ctrl_q.grb;
    assign Grc             = ctrl_q.grc;
    assign Rin             = ctrl_q.rin;
    assign Rout            = ctrl_q.rout;
    assign BAout           = ctrl_q.baout;
    assign enable          = ctrl_q.en;
    assign busSelect       = ctrl_q.sel;
    assign Control_Signals = ctrl_q.cs;
    assign step            = ctrl_q.step;
    assign illegal         = illegal_q;
    assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized self-checking bench for ctrl_sequencer. The reference model walks
// instructions as lists of named control signals per step and compares every
// cycle. Inputs change on the falling edge and outputs are checked there too.
module tb_ctrl_sequencer;

    localparam int EN_W = 32, SEL_W = 32, MEM_TIMEOUT = 15;
    localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2;
    localparam int K_R = 0, K_MD = 1, K_LD = 2, K_ST = 3, K_NOP = 4;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic [31:0]      ir = '0;
    logic             mem_ready = 1'b1;
    logic             Stop = 1'b0;
    logic             run, MD_Read, ReadRAM, WriteRAM;
    logic             Gra, Grb, Grc, Rin, Rout, BAout;
    logic [EN_W-1:0]  enable;
    logic [SEL_W-1:0] busSelect;
    logic [4:0]       Control_Signals;
    logic [2:0]       step;
    logic             illegal, mem_err;

    ctrl_sequencer #(.EN_W(EN_W), .SEL_W(SEL_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .Reset(Reset), .ir(ir), .mem_ready(mem_ready), .Stop(Stop),
        .run(run), .MD_Read(MD_Read), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .enable(enable), .busSelect(busSelect), .Control_Signals(Control_Signals),
        .step(step), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_mode, m_step, m_kind, m_wait;
    logic [4:0] m_opc;
    bit         m_stop, m_ill, m_err;

    logic             e_run, e_mdr, e_rram, e_wram, e_gra, e_grb, e_grc, e_rin, e_rout, e_baout;
    logic [EN_W-1:0]  e_en;
    logic [SEL_W-1:0] e_sel;
    logic [4:0]       e_cs;

    // Control signal names asserted in each step, straight from the step tables.
    function automatic string step_controls(int kind, int st);
        if (st == 0) return "PCout MARin Zin IncPC";
        if (st == 1) return "Zlowout PCin MDRin MD_Read ReadRAM";
        if (st == 2) return "MDRout IRin";
        case (kind)
            K_R: case (st)
                3: return "Grb Rout Yin";
                4: return "Grc Rout Zin ALU";
                5: return "Zlowout Gra Rin";
                default: return "";
            endcase
            K_MD: case (st)
                3: return "Gra Rout Yin";
                4: return "Grb Rout Zin ALU";
                5: return "Zlowout LOin";
                6: return "Zhighout HIin";
                default: return "";
            endcase
            K_LD, K_ST: case (st)
                3: return "Grb BAout Yin";
                4: return "Cout Zin ADD";
                5: return "Zlowout MARin";
                6: return (kind == K_LD) ? "ReadRAM MD_Read MDRin" : "Gra Rout MDRin";
                7: return (kind == K_LD) ? "MDRout Gra Rin" : "WriteRAM";
                default: return "";
            endcase
            default: return "";
        endcase
    endfunction

    task automatic apply_token(input string t);
        case (t)
            "PCout":    e_sel[20] = 1'b1;
            "Zhighout": e_sel[18] = 1'b1;
            "Zlowout":  e_sel[19] = 1'b1;
            "MDRout":   e_sel[21] = 1'b1;
            "Cout":     e_sel[22] = 1'b1;
            "Zin":      e_en[18] = 1'b1;
            "Yin":      e_en[19] = 1'b1;
            "PCin":     e_en[20] = 1'b1;
            "MDRin":    e_en[21] = 1'b1;
            "HIin":     e_en[22] = 1'b1;
            "LOin":     e_en[23] = 1'b1;
            "IRin":     e_en[24] = 1'b1;
            "MARin":    e_en[25] = 1'b1;
            "MD_Read":  e_mdr = 1'b1;
            "ReadRAM":  e_rram = 1'b1;
            "WriteRAM": e_wram = 1'b1;
            "Gra":      e_gra = 1'b1;
            "Grb":      e_grb = 1'b1;
            "Grc":      e_grc = 1'b1;
            "Rin":      e_rin = 1'b1;
            "Rout":     e_rout = 1'b1;
            "BAout":    e_baout = 1'b1;
            "IncPC":    e_cs = 5'd14;
            "ADD":      e_cs = 5'd3;
            "ALU":      e_cs = m_opc;
            default: ;
        endcase
    endtask

    task automatic build_expected();
        string s;
        int    start;
        {e_run, e_mdr, e_rram, e_wram, e_gra, e_grb, e_grc, e_rin, e_rout, e_baout} = '0;
        e_en = '0; e_sel = '0; e_cs = '0;
        if (m_mode == M_RUN) begin
            e_run = 1'b1;
            s = step_controls(m_kind, m_step);
            start = 0;
            for (int i = 0; i <= s.len(); i++) begin
                if (i == s.len() || s[i] == " ") begin
                    if (i > start) apply_token(s.substr(start, i - 1));
                    start = i + 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        build_expected();
        check("step", 64'(step), (m_mode == M_RUN) ? 64'(m_step) : 64'd0);
        check("ctrl", 64'({run, MD_Read, ReadRAM, WriteRAM, Gra, Grb, Grc, Rin, Rout, BAout}),
              64'({e_run, e_mdr, e_rram, e_wram, e_gra, e_grb, e_grc, e_rin, e_rout, e_baout}));
        check("enable", 64'(enable), 64'(e_en));
        check("busSelect", 64'(busSelect), 64'(e_sel));
        check("alu_op", 64'(Control_Signals), 64'(e_cs));
        check("flags", 64'({illegal, mem_err}), 64'({m_ill, m_err}));
    endtask

    function automatic int last_step();
        case (m_kind)
            K_R:        return 5;
            K_MD:       return 6;
            K_LD, K_ST: return 7;
            default:    return 3;
        endcase
    endfunction

    function automatic bit mem_step();
        return m_step == 1 || (m_kind == K_LD && m_step == 6) || (m_kind == K_ST && m_step == 7);
    endfunction

    task automatic decode_ir();
        m_opc = ir[31:27];
        m_step = 3;
        if (m_opc >= 5'd3 && m_opc <= 5'd9) m_kind = K_R;
        else if (m_opc == 5'd15 || m_opc == 5'd16) m_kind = K_MD;
        else if (m_opc == 5'd0) m_kind = K_LD;
        else if (m_opc == 5'd2) m_kind = K_ST;
        else if (m_opc == 5'd26) m_kind = K_NOP;
        else if (m_opc == 5'd27) m_mode = M_HALT;
        else begin m_kind = K_NOP; m_ill = 1'b1; end
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        if (m_mode == M_RUN && Stop) m_stop = 1'b1;
        case (m_mode)
            M_RESET: begin m_mode = M_RUN; m_step = 0; m_wait = 0; end
            M_RUN: begin
                if (mem_step() && !mem_ready) begin
                    m_wait++;
                    if (m_wait == MEM_TIMEOUT) begin m_err = 1'b1; m_mode = M_HALT; end
                end else begin
                    m_wait = 0;
                    if (m_step == 2) decode_ir();
                    else if (m_step == last_step()) begin
                        m_step = 0;
                        if (m_stop) m_mode = M_HALT;
                    end else m_step++;
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- stimulus ----------------
    function automatic bit is_legal(logic [4:0] o);
        return o inside {5'd0, 5'd2, [5'd3:5'd9], 5'd15, 5'd16, 5'd26, 5'd27};
    endfunction

    function automatic logic [4:0] pick_opcode(bit allow_halt);
        int r;
        logic [4:0] o;
        r = $urandom_range(0, 99);
        if (r < 40)      o = 5'($urandom_range(3, 9));
        else if (r < 50) o = ($urandom_range(0, 1) == 1) ? 5'd15 : 5'd16;
        else if (r < 64) o = 5'd0;
        else if (r < 78) o = 5'd2;
        else if (r < 86) o = 5'd26;
        else if (r < 96 || !allow_halt) begin
            do o = 5'($urandom_range(0, 31)); while (is_legal(o));
        end
        else o = 5'd27;
        return o;
    endfunction

    // Asynchronous reset in the middle of a cycle: outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_ctrl", 64'({run, MD_Read, ReadRAM, WriteRAM, Gra, Grb, Grc, Rin, Rout, BAout,
                                     Control_Signals, step, illegal, mem_err}), 64'd0);
        check("async_rst_enable", 64'(enable), 64'd0);
        check("async_rst_busSelect", 64'(busSelect), 64'd0);
        m_mode = M_RESET; m_step = 0; m_kind = K_NOP; m_wait = 0; m_opc = '0;
        m_stop = 1'b0; m_ill = 1'b0; m_err = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic run_episode(input int ncyc, input int p_ready, input int p_stop_pm, input bit allow_halt);
        logic [31:0] rnd;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            check_outputs();
            rnd       = $urandom();
            ir        = {pick_opcode(allow_halt), rnd[26:0]};
            mem_ready = ($urandom_range(0, 99) < p_ready);
            Stop      = ($urandom_range(0, 999) < p_stop_pm);
            model_edge();
            @(negedge clk);
        end
        check_outputs();
    endtask

    initial begin
        int ready_opts[5] = '{100, 90, 60, 25, 8};
        int stop_opts[3]  = '{0, 10, 40};
        // Clean run with memory always ready and no Stop.
        run_episode(60, 100, 0, 1'b0);
        // Memory never ready: timeout in T1 then halted.
        run_episode(30, 0, 0, 1'b0);
        for (int e = 0; e < 40; e++) begin
            run_episode($urandom_range(80, 200),
                        ready_opts[$urandom_range(0, 4)],
                        stop_opts[$urandom_range(0, 2)],
                        ($urandom_range(0, 3) == 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised multi-cycle control unit (Moore FSM) for the Phase-3 datapath.
- Sequences fetch (T0-T2) and execute steps (T3-T7) from the IR opcode.
- Drives register-file select (Gra/Grb/Grc, Rin/Rout, BAout), one-hot datapath enables, the one-hot bus-source select and the ALU op code.
- Beyond the previous unit: memory-ready handshake with stall, bounded memory timeout, Stop honoured only at instruction boundaries, illegal-opcode detection, and widths set by parameters.

Parameters:
EN_W, 32, width of enable vector; must be >= 26
SEL_W, 32, width of busSelect vector; must be >= 23
MEM_TIMEOUT, 15, max stall cycles per memory step before error (1..255)

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
ir  in  32  instruction register; opcode = ir[31:27]
mem_ready  in  1  memory completes the current ReadRAM/WriteRAM step
Stop  in  1  halt request, level-sampled on clk
run  out  1  1 while executing
MD_Read, ReadRAM, WriteRAM  out  1 each  memory controls
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/control
enable  out  EN_W  one-hot register load enables
busSelect  out  SEL_W  one-hot bus driver select
Control_Signals  out  5  ALU op code (0 = idle)
step  out  3  current step T0..T7
illegal  out  1  sticky: unknown opcode seen
mem_err  out  1  sticky: memory timeout

Behaviour:
- Interface: one clock `clk`; `Reset` is asynchronous and active-high. All outputs are decoded from registered state only, with no glitch-through from `ir`.
- Reset: state=RESET, all outputs 0 except run=0. On the first clk after Reset deasserts, go to T0 with run=1.
- enable bit map: 18 Zin, 19 Yin, 20 PCin, 21 MDRin, 22 HIin, 23 LOin, 24 IRin, 25 MARin. All other bits are 0.
- busSelect bit map: 16 HIout, 17 LOout, 18 Zhighout, 19 Zlowout, 20 PCout, 21 MDRout, 22 Cout.
- Control_Signals: 14 = IncPC. Otherwise it carries the opcode during ALU steps.
- Fetch:
  - T0: PCout, MARin, Zin, Control_Signals=14.
  - T1: Zlowout, PCin, MDRin, MD_Read, ReadRAM.
  - T2: MDRout, IRin.
  - Decode of `ir` occurs in T2; next state is T3.
- R-type, opcodes 00011..01001:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, Control_Signals=opcode.
  - T5: Zlowout, Gra, Rin.
- mul 01111 / div 10000:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin, op.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
- ld 00000:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, Control_Signals=3.
  - T5: Zlowout, MARin.
  - T6: ReadRAM, MD_Read, MDRin.
  - T7: MDRout, Gra, Rin.
- st 00010:
  - T3-T5 as ld.
  - T6: Gra, Rout, MDRin (MD_Read=0).
  - T7: WriteRAM.
- nop 11010: T3 with no controls asserted.
- halt 11011: go to HALTED.
- Any other opcode: set illegal=1 and treat as nop.
- Memory stall:
  - Applies to any step asserting ReadRAM or WriteRAM (T1, ld T6, st T7).
  - The step holds while mem_ready=0, with outputs held and step unchanged.
  - It advances on the clk where mem_ready=1.
  - An 8-bit wait counter clears on step entry.
  - After MEM_TIMEOUT cycles without ready: set mem_err=1 and go to HALTED.
- Instruction boundary = last execute step.
  - Next state is T0, unless Stop pending → HALTED.
  - Stop pending is set when Stop=1 is sampled on any clk while run=1, and cleared by Reset only.
  - Stop asserted during T0 still completes the current instruction.
- HALTED:
  - run=0 and all control outputs 0.
  - illegal and mem_err are held.
  - Exit only via Reset.
- Reset mid-operation (including during a stall): immediate return to RESET state; sticky flags clear.

Test Plan:
- Reset then add (ir[31:27]=00011), mem_ready=1 → T0..T5 in 6 cycles. T0: busSelect[20], enable[25], enable[18] set and Control_Signals=14. T4: Control_Signals=3. T5: busSelect[19], Gra, Rin set.
- ld with mem_ready low 4 cycles in T6 → T6 held 5 cycles with ReadRAM=1 throughout, then T7 asserts busSelect[21], Gra, Rin; mem_err=0.
- mem_ready stuck 0 in T1, MEM_TIMEOUT=15 → mem_err=1 after 15 stall cycles, run=0, all enables 0.
- Stop pulsed one cycle during mul T3 → T4..T6 complete, HIin asserted at T6, then HALTED; no further T0.
- ir opcode 11111 → illegal=1, one T3 idle cycle, next T0; flag stays 1 until Reset.
- Reset asserted mid-st T6 → all outputs 0 asynchronously; T0 on first clk after release.
